// File: rtl/demultiplexor_buf.sv
// Registered 1-to-2 demultiplexor with a one-entry holding register, valid/ready
// handshakes on both sides and a wrap-around delivery counter per destination.
//
// state | meaning
// EMPTY | holding register free, in_ready=1
// FULL0 | holding register owns a word for out0
// FULL1 | holding register owns a word for out1
module demultiplexor_buf #(
    parameter int WIDTH     = 5,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in,
    input  logic                 sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out0,
    output logic                 out0_valid,
    input  logic                 out0_ready,
    output logic [WIDTH-1:0]     out1,
    output logic                 out1_valid,
    input  logic                 out1_ready,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL0 = 2'b01,
        FULL1 = 2'b10
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] data;
    logic             deliver0;
    logic             deliver1;
    logic             accept;

    // A ready on the destination that does not own the word is ignored here.
    assign deliver0 = (state == FULL0) && out0_ready;
    assign deliver1 = (state == FULL1) && out1_ready;

    // Pass-through: a word leaving this cycle frees the register for a new one.
    assign in_ready = (state == EMPTY) || deliver0 || deliver1;
    assign accept   = in_valid && in_ready;

    assign out0       = data;
    assign out1       = data;
    assign out0_valid = (state == FULL0);
    assign out1_valid = (state == FULL1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            data  <= '0;
        end else if (accept) begin
            data  <= in;
            state <= sel ? FULL1 : FULL0;
        end else if (deliver0 || deliver1) begin
            state <= EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (deliver0) cnt0 <= cnt0 + CNT_ONE;
            if (deliver1) cnt1 <= cnt1 + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_demultiplexor_buf.sv
// Bench for demultiplexor_buf: directed scenarios plus random traffic, checked
// against a one-entry queue model with modulo delivery counters.
module tb_demultiplexor_buf;

    localparam int W  = 5;
    localparam int CW = 2;
    localparam int CMOD = 1 << CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  in = '0;
    logic          sel = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out0;
    logic          out0_valid;
    logic          out0_ready = 1'b0;
    logic [W-1:0]  out1;
    logic          out1_valid;
    logic          out1_ready = 1'b0;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    demultiplexor_buf #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .out0(out0), .out0_valid(out0_valid),
        .out0_ready(out0_ready), .out1(out1), .out1_valid(out1_valid),
        .out1_ready(out1_ready), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: queue of at most one {dest, word}, last loaded word, delivery counts.
    typedef struct { int dest; int word; } entry_t;
    entry_t q[$];
    int     last_word = 0;
    int     dcount[2] = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_ready(input int r0, input int r1);
        if (q.size() == 0) return 1;
        return (q[0].dest == 0) ? r0 : r1;
    endfunction

    task automatic check_outputs(input string tag, input int r0, input int r1);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready(r0, r1)));
        chk({tag, ".out0_valid"}, 32'(out0_valid), 32'((q.size() > 0 && q[0].dest == 0) ? 1 : 0));
        chk({tag, ".out1_valid"}, 32'(out1_valid), 32'((q.size() > 0 && q[0].dest == 1) ? 1 : 0));
        chk({tag, ".out0"}, 32'(out0), 32'(last_word));
        chk({tag, ".out1"}, 32'(out1), 32'(last_word));
        chk({tag, ".cnt0"}, 32'(cnt0), 32'(dcount[0]));
        chk({tag, ".cnt1"}, 32'(cnt1), 32'(dcount[1]));
    endtask

    // One clock cycle: drive at negedge, check just after, advance model at posedge.
    task automatic step(input string tag, input int v, input int s, input int d,
                        input int r0, input int r1);
        int     delivered;
        int     accepted;
        entry_t e;
        @(negedge clk);
        in_valid   = v[0];
        sel        = s[0];
        in         = W'(d);
        out0_ready = r0[0];
        out1_ready = r1[0];
        #1;
        check_outputs(tag, r0, r1);
        delivered = (q.size() > 0) && (((q[0].dest == 0) ? r0 : r1) != 0);
        accepted  = v && exp_ready(r0, r1);
        @(posedge clk);
        if (delivered) begin
            dcount[q[0].dest] = (dcount[q[0].dest] + 1) % CMOD;
            void'(q.pop_front());
        end
        if (accepted) begin
            e.dest = s;
            e.word = d % (1 << W);
            q.push_back(e);
            last_word = e.word;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        last_word = 0;
        dcount = '{0, 0};
        #1;
        chk({tag, ".rst_out0_valid"}, 32'(out0_valid), 32'd0);
        chk({tag, ".rst_out1_valid"}, 32'(out1_valid), 32'd0);
        chk({tag, ".rst_data"}, 32'(out0), 32'd0);
        chk({tag, ".rst_cnt0"}, 32'(cnt0), 32'd0);
        chk({tag, ".rst_cnt1"}, 32'(cnt1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        chk({tag, ".rel_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        // 1: reset
        do_reset("t1");

        // 2: basic steer to out0
        step("t2a", 1, 0, 5'b00001, 1, 0);
        step("t2b", 0, 0, 0, 1, 0);
        step("t2c", 0, 0, 0, 1, 0);
        chk("t2.cnt0_is_1", 32'(cnt0), 32'd1);

        // 3: backpressure on out1 for 3 cycles, then release
        step("t3a", 1, 1, 5'b10101, 0, 0);
        for (int i = 0; i < 3; i++) step("t3hold", 1, 0, 5'b01010, 0, 0);
        step("t3rel", 0, 0, 0, 0, 1);
        step("t3post", 0, 0, 0, 0, 1);
        chk("t3.cnt1_is_1", 32'(cnt1), 32'd1);

        // 4: streaming alternating destinations, data 1..4
        for (int i = 1; i <= 4; i++) step("t4", 1, (i - 1) % 2, i, 1, 1);
        step("t4drain", 0, 0, 0, 1, 1);
        step("t4done", 0, 0, 0, 1, 1);
        chk("t4.cnt0", 32'(cnt0), 32'((1 + 2) % CMOD));
        chk("t4.cnt1", 32'(cnt1), 32'((1 + 2) % CMOD));

        // 5: cross-ready ignored while FULL0
        step("t5load", 1, 0, 5'b00111, 0, 0);
        for (int i = 0; i < 3; i++) step("t5cross", 1, 1, 5'b11000, 0, 1);
        step("t5rel", 0, 0, 0, 1, 0);
        step("t5post", 0, 0, 0, 0, 0);

        // 6: counter wrap after 5 deliveries, then reset while FULL1
        do_reset("t6r");
        for (int i = 0; i < 5; i++) step("t6wrap", 1, 0, i + 3, 1, 0);
        step("t6drain", 0, 0, 0, 1, 0);
        step("t6chk", 0, 0, 0, 0, 0);
        chk("t6.cnt0_wrap", 32'(cnt0), 32'd1);
        step("t6full1", 1, 1, 5'b11111, 0, 0);
        step("t6hold", 0, 0, 0, 0, 0);
        do_reset("t6mid");
        step("t6after", 0, 0, 0, 0, 1);
        step("t6after2", 0, 0, 0, 0, 1);
        chk("t6.cnt1_zero", 32'(cnt1), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1),
                 $urandom_range(0, 31), ($urandom_range(0, 2) != 0) ? 1 : 0,
                 ($urandom_range(0, 2) != 0) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
